// File: rtl/ascon_ctrl_fsm_pkg.sv
// Shared types and constants for the ASCON-128 control FSM.
package ascon_pack;

    localparam int unsigned RC_W       = 4;
    localparam int unsigned ROUNDS_A   = 12;
    localparam int unsigned ROUNDS_B   = 6;
    localparam logic [3:0]  LAST_ROUND = 4'd11;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_INIT_RUN = 3'd1,
        S_WAIT_AD  = 3'd2,
        S_AD_RUN   = 3'd3,
        S_WAIT_PT  = 3'd4,
        S_PT_RUN   = 3'd5,
        S_FIN_RUN  = 3'd6,
        S_DONE     = 3'd7
    } ctrl_state_t;

endpackage

// File: rtl/ascon_ctrl_fsm_round_counter.sv
// Round-constant counter: load, saturating increment, last-round flag.
module ascon_round_counter
    import ascon_pack::*;
(
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic [RC_W-1:0] load_val_i,
    input  logic            inc_i,
    output logic [RC_W-1:0] rc_o,
    output logic            last_o
);

    logic [RC_W-1:0] rc_q;
    logic [RC_W-1:0] rc_d;

    // Load wins over increment; never step past the last round.
    always_comb begin
        rc_d = rc_q;
        if (load_i) begin
            rc_d = load_val_i;
        end else if (inc_i && (rc_q != LAST_ROUND)) begin
            rc_d = rc_q + RC_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rc_q <= '0;
        end else begin
            rc_q <= rc_d;
        end
    end

    assign rc_o   = rc_q;
    assign last_o = (rc_q == LAST_ROUND);

endmodule

// File: rtl/ascon_ctrl_fsm.sv
// Control FSM sequencing the ASCON-128 permutation datapath through
// initialisation, AD, plaintext and finalisation.
module ascon_ctrl_fsm
    import ascon_pack::*;
#(
    parameter int unsigned ROUNDS_A = ascon_pack::ROUNDS_A,
    parameter int unsigned ROUNDS_B = ascon_pack::ROUNDS_B
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            data_valid_i,
    input  logic            ad_last_i,
    input  logic            pt_last_i,
    output logic            data_ready_o,
    output logic            selectionp_o,
    output logic            enable_o,
    output logic            bypass_begin_o,
    output logic            bypass_end_o,
    output logic            mode_int_ext_o,
    output logic            mode_init_data_o,
    output logic [RC_W-1:0] round_o,
    output logic            cipher_valid_o,
    output logic            tag_valid_o,
    output logic            busy_o
);

    localparam logic [RC_W-1:0] RC_A_FIRST = RC_W'(13 - ROUNDS_A);
    localparam logic [RC_W-1:0] RC_B_FIRST = RC_W'(13 - ROUNDS_B);
    localparam logic [RC_W-1:0] RC_B_ZERO  = RC_W'(12 - ROUNDS_B);
    localparam logic [RC_W-1:0] RC_A_ZERO  = RC_W'(12 - ROUNDS_A);

    ctrl_state_t     state_q, state_d;
    logic            ad_last_q, ad_last_d;
    logic            rc_load, rc_inc, rc_last;
    logic [RC_W-1:0] rc_load_val, rc;

    ascon_round_counter u_rc (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .load_i     (rc_load),
        .load_val_i (rc_load_val),
        .inc_i      (rc_inc),
        .rc_o       (rc),
        .last_o     (rc_last)
    );

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            ad_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ad_last_q <= ad_last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ad_last_d   = ad_last_q;
        rc_load     = 1'b0;
        rc_load_val = '0;
        rc_inc      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = S_INIT_RUN;
                    rc_load     = 1'b1;
                    rc_load_val = RC_A_FIRST;
                end
            end
            S_INIT_RUN: begin
                if (rc_last) state_d = S_WAIT_AD;
                else         rc_inc  = 1'b1;
            end
            S_WAIT_AD: begin
                if (data_valid_i) begin
                    state_d     = S_AD_RUN;
                    ad_last_d   = ad_last_i;
                    rc_load     = 1'b1;
                    rc_load_val = RC_B_FIRST;
                end
            end
            S_AD_RUN: begin
                if (rc_last) state_d = ad_last_q ? S_WAIT_PT : S_WAIT_AD;
                else         rc_inc  = 1'b1;
            end
            S_WAIT_PT: begin
                if (data_valid_i) begin
                    rc_load = 1'b1;
                    if (pt_last_i) begin
                        state_d     = S_FIN_RUN;
                        rc_load_val = RC_A_FIRST;
                    end else begin
                        state_d     = S_PT_RUN;
                        rc_load_val = RC_B_FIRST;
                    end
                end
            end
            S_PT_RUN: begin
                if (rc_last) state_d = S_WAIT_PT;
                else         rc_inc  = 1'b1;
            end
            S_FIN_RUN: begin
                if (rc_last) state_d = S_DONE;
                else         rc_inc  = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                rc_load = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                rc_load = 1'b1;
            end
        endcase
    end

    // Datapath controls fall back to their quiet defaults while reset is asserted.
    always_comb begin
        data_ready_o     = 1'b0;
        selectionp_o     = 1'b1;
        enable_o         = 1'b0;
        bypass_begin_o   = 1'b1;
        bypass_end_o     = 1'b1;
        mode_int_ext_o   = 1'b0;
        mode_init_data_o = 1'b0;
        round_o          = '0;
        cipher_valid_o   = 1'b0;
        tag_valid_o      = 1'b0;
        if (!reset_i) begin
            case (state_q)
                S_IDLE: begin
                    selectionp_o = 1'b0;
                    enable_o     = start_i;
                    round_o      = RC_A_ZERO;
                end
                S_INIT_RUN, S_FIN_RUN: begin
                    enable_o = 1'b1;
                    round_o  = rc;
                    if (rc_last) bypass_end_o = 1'b0;
                end
                S_WAIT_AD: begin
                    data_ready_o   = 1'b1;
                    enable_o       = data_valid_i;
                    round_o        = RC_B_ZERO;
                    bypass_begin_o = 1'b0;
                end
                S_AD_RUN: begin
                    enable_o = 1'b1;
                    round_o  = rc;
                    if (rc_last && ad_last_q) begin
                        bypass_end_o     = 1'b0;
                        mode_init_data_o = 1'b1;
                    end
                end
                S_WAIT_PT: begin
                    data_ready_o   = 1'b1;
                    enable_o       = data_valid_i;
                    bypass_begin_o = 1'b0;
                    cipher_valid_o = data_valid_i;
                    mode_int_ext_o = pt_last_i;
                    round_o        = pt_last_i ? RC_A_ZERO : RC_B_ZERO;
                end
                S_PT_RUN: begin
                    enable_o = 1'b1;
                    round_o  = rc;
                end
                S_DONE: begin
                    tag_valid_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy_o = (state_q != S_IDLE);

endmodule

// File: doc/ascon_ctrl_fsm.md
Name: ascon_ctrl_fsm

Overview:
- Control FSM that sequences the ASCON-128 permutation datapath stage: initialisation, associated data (AD), plaintext (PT) and finalisation.
- Sits directly upstream of the datapath stage. Drives its mux select, register enable, begin/end XOR bypasses and modes, and round index.
- Runs the block-input handshake and flags when ciphertext and tag are valid on the datapath outputs.

Parameters:
- ROUNDS_A, 12, rounds of p^a (initialisation and finalisation).
- ROUNDS_B, 6, rounds of p^b (AD and intermediate PT blocks).

Ports:
- clock_i  in  1  system clock.
- reset_i  in  1  synchronous reset, active-high.
- start_i  in  1  begin a new encryption; ignored unless in IDLE.
- data_valid_i  in  1  64-bit AD/PT block present on datapath data_i.
- ad_last_i  in  1  qualifies the current AD block as the last one.
- pt_last_i  in  1  qualifies the current PT block as the last one (already padded).
- data_ready_o  out  1  FSM accepts a block this cycle.
- selectionp_o  out  1  0 loads the initial state (IV||K||N); 1 feeds back the register.
- enable_o  out  1  datapath state-register enable.
- bypass_begin_o  out  1  1 disables the begin XOR.
- bypass_end_o  out  1  1 disables the end XOR.
- mode_int_ext_o  out  1  0 XORs data into S0; 1 XORs data into S0 and key into S1,S2.
- mode_init_data_o  out  1  0 XORs key into S3,S4; 1 XORs 1 into LSB of S4 (domain separation).
- round_o  out  4  round-constant index, 0..11.
- cipher_valid_o  out  1  datapath S0 XOR data_i equals ciphertext this cycle.
- tag_valid_o  out  1  S3||S4 on the datapath output is the tag.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- States: IDLE, INIT_RUN, WAIT_AD, AD_RUN, WAIT_PT, PT_RUN, FIN_RUN, DONE. A 4-bit round counter rc is held in state.
- Control outputs are combinational decodes of state, rc and data_valid_i. Defaults: selectionp_o=1, enable_o=0, both bypasses=1, modes=0, round_o=0, all status outputs 0.
- Reset (any time, including mid-operation): state=IDLE, rc=0. No output pulses in the cycle after reset. A partial message is abandoned.
- IDLE:
  - selectionp_o=0, round_o=0, enable_o=start_i.
  - On start_i → INIT_RUN with rc=1. The IDLE cycle carrying start_i is round 0.
- INIT_RUN:
  - enable_o=1, round_o=rc. rc increments each cycle.
  - At rc=11: bypass_end_o=0, mode_init_data_o=0 (key XOR into S3,S4). Then → WAIT_AD.
- WAIT_AD:
  - data_ready_o=1, enable_o=data_valid_i, round_o=12-ROUNDS_B (6), bypass_begin_o=0, mode_int_ext_o=0.
  - On accept: latch ad_last_i, rc=7, → AD_RUN.
  - Acceptance cycle is the block's first round; data_i is consumed in that cycle.
- AD_RUN:
  - enable_o=1, rounds 7..11.
  - At rc=11: if latched last, bypass_end_o=0 and mode_init_data_o=1, then → WAIT_PT; otherwise → WAIT_AD.
- AD policy: at least one AD block per message. Upstream supplies a padded block when AD is empty.
- WAIT_PT:
  - data_ready_o=1, enable_o=data_valid_i, bypass_begin_o=0, cipher_valid_o=data_valid_i.
  - If pt_last_i: round_o=0, mode_int_ext_o=1; on accept rc=1 → FIN_RUN.
  - Else: round_o=6, mode_int_ext_o=0; on accept rc=7 → PT_RUN.
- PT_RUN: rounds 7..11, no end XOR, then → WAIT_PT.
- FIN_RUN: rounds 1..11. At rc=11: bypass_end_o=0, mode_init_data_o=0. Then → DONE.
- DONE: tag_valid_o=1 for exactly one cycle, enable_o=0. Then → IDLE.
- Boundary conditions:
  - data_valid_i outside WAIT_* is ignored (data_ready_o=0).
  - ad_last_i and pt_last_i are sampled only on accept.
  - start_i outside IDLE is ignored.
  - start_i in DONE is ignored; the next start is taken in IDLE.
  - Back-to-back accept is allowed. Ready reasserts exactly ROUNDS_B cycles after an accept.
  - rc never exceeds 11. An illegal state encoding returns to IDLE.

Decomposition:
- ascon_pack: enum ctrl_state_t, constants ROUNDS_A, ROUNDS_B, LAST_ROUND=4'd11.
- One sub-module, ascon_round_counter: 4-bit load/increment counter with a last-round flag.

Test Plan:
- Reset held, start_i=1 → enable_o=0, busy_o=0, tag_valid_o=0. Release reset → next cycle enable_o=1, selectionp_o=0, round_o=0.
- start at cycle 0, valid held with ad_last=1 then pt_last=1:
  - round_o 0..11 on cycles 0..11, bypass_end_o=0 on cycle 11.
  - AD accept on cycle 12 (round 6), domain separation on cycle 17.
  - Final accept on cycle 18 (round 0, mode_int_ext_o=1), cipher_valid_o=1 on cycle 18.
  - tag_valid_o on cycle 30, busy_o=0 on cycle 31.
- Two AD blocks (ad_last 0 then 1) → no end XOR on the first block's round 11. mode_init_data_o=1 only on the second.
- Two PT blocks → cipher_valid_o pulses on both accepts. Only the second is round 0 with mode_int_ext_o=1.
- data_valid_i low for 5 cycles in WAIT_AD → data_ready_o=1, enable_o=0 throughout, round_o stays 6.
- reset_i at FIN_RUN rc=5 → IDLE next cycle, no tag_valid_o. start_i pulses during INIT_RUN are ignored.
